// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes, fetch states and length/legality helpers.
package y86_pkg;

    localparam logic [3:0] IcHalt   = 4'h0;
    localparam logic [3:0] IcNop    = 4'h1;
    localparam logic [3:0] IcRrmovq = 4'h2;
    localparam logic [3:0] IcIrmovq = 4'h3;
    localparam logic [3:0] IcRmmovq = 4'h4;
    localparam logic [3:0] IcMrmovq = 4'h5;
    localparam logic [3:0] IcOpq    = 4'h6;
    localparam logic [3:0] IcJxx    = 4'h7;
    localparam logic [3:0] IcCall   = 4'h8;
    localparam logic [3:0] IcRet    = 4'h9;
    localparam logic [3:0] IcPushq  = 4'hA;
    localparam logic [3:0] IcPopq   = 4'hB;

    localparam logic [3:0] RegNone = 4'hF;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef enum logic [1:0] {StIdle, StRun, StHalt, StErr} fetch_state_e;

    // Illegal icodes report length 1 so the address check only covers the opcode byte.
    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        logic [3:0] len;
        case (ic)
            IcHalt, IcNop, IcRet:                 len = 4'd1;
            IcRrmovq, IcOpq, IcPushq, IcPopq:     len = 4'd2;
            IcIrmovq, IcRmmovq, IcMrmovq:         len = 4'd10;
            IcJxx, IcCall:                        len = 4'd9;
            default:                              len = 4'd1;
        endcase
        return len;
    endfunction

    function automatic logic ifun_legal(input logic [3:0] ic, input logic [3:0] fn);
        logic ok;
        case (ic)
            IcRrmovq: ok = (fn <= 4'd6);
            IcOpq:    ok = (fn <= 4'd3);
            IcJxx:    ok = (fn <= 4'd6);
            default:  ok = (ic <= IcPopq) && (fn == 4'd0);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Byte-addressed instruction memory: one synchronous write port, ten combinational read bytes.
module instr_mem #(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        we,
    input  logic [63:0] waddr,
    input  logic [7:0]  wdata,
    input  logic [63:0] raddr,
    output logic [79:0] rdata
);

    localparam int unsigned AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [64:0] MemLimit = 65'(IMEM_BYTES);

    logic [7:0] mem [IMEM_BYTES];

    always_ff @(posedge clock) begin
        if (we && ({1'b0, waddr} < MemLimit)) begin
            mem[waddr[AW-1:0]] <= wdata;
        end
    end

    // Byte i of rdata is the byte at raddr+i; reads past the end (or past 2^64) return zero.
    for (genvar i = 0; i < 10; i++) begin : g_rd
        logic [64:0] addr;
        assign addr = {1'b0, raddr} + 65'(i);
        assign rdata[8*i +: 8] = (addr < MemLimit) ? mem[addr[AW-1:0]] : 8'h00;
    end

endmodule

// File: rtl/y86_fetch_pc.sv
// SEQ fetch and PC-update stage: PC/icount registers, run/halt/error FSM, field split and
// next-PC selection around an internal instruction memory.
module y86_fetch_pc
    import y86_pkg::*;
#(
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        imem_we,
    input  logic [63:0] imem_addr,
    input  logic [7:0]  imem_wdata,
    input  logic        start,
    input  logic        stall,
    input  logic        cond,
    input  logic [63:0] valM,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [63:0] pc,
    output logic [2:0]  stat,
    output logic        instr_valid,
    output logic [31:0] icount
);

    localparam logic [64:0] MemLimit = 65'(IMEM_BYTES);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  icount_q, icount_d;
    logic [2:0]   stat_q, stat_d;

    logic [79:0]  ibytes;
    logic         mem_we;

    assign mem_we = imem_we && (state_q == StIdle);

    instr_mem #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_imem (
        .clock(clock),
        .we   (mem_we),
        .waddr(imem_addr),
        .wdata(imem_wdata),
        .raddr(pc_q),
        .rdata(ibytes)
    );

    logic [3:0]  f_icode, f_ifun, f_ra, f_rb, f_len;
    logic [63:0] f_valc, f_valp, next_pc;
    logic [64:0] last_byte;
    logic [2:0]  f_stat;

    always_comb begin
        f_icode = ibytes[7:4];
        f_ifun  = ibytes[3:0];
        f_len   = instr_len(f_icode);
        f_ra    = RegNone;
        f_rb    = RegNone;
        f_valc  = '0;
        if (f_len == 4'd2 || f_len == 4'd10) begin
            f_ra = ibytes[15:12];
            f_rb = ibytes[11:8];
        end
        if (f_len == 4'd10) begin
            f_valc = ibytes[79:16];
        end else if (f_len == 4'd9) begin
            f_valc = ibytes[71:8];
        end
        f_valp = pc_q + 64'(f_len);
        // 65-bit sum so an instruction straddling 2^64 is also an address fault.
        last_byte = {1'b0, pc_q} + 65'(f_len) - 65'd1;
        if (last_byte >= MemLimit) begin
            f_stat = StatAdr;
        end else if (!ifun_legal(f_icode, f_ifun)) begin
            f_stat = StatIns;
        end else if (f_icode == IcHalt) begin
            f_stat = StatHlt;
        end else begin
            f_stat = StatAok;
        end
    end

    always_comb begin
        case (f_icode)
            IcJxx:   next_pc = cond ? f_valc : f_valp;
            IcCall:  next_pc = f_valc;
            IcRet:   next_pc = valM;
            default: next_pc = f_valp;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        stat_d   = stat_q;
        case (state_q)
            StIdle: begin
                stat_d = StatAok;
                if (start) begin
                    state_d = StRun;
                    pc_d    = RESET_PC;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (f_stat == StatAok) begin
                        pc_d     = next_pc;
                        icount_d = icount_q + 32'd1;
                    end else begin
                        // pc stays on the faulting instruction for diagnosis.
                        stat_d  = f_stat;
                        state_d = (f_stat == StatHlt) ? StHalt : StErr;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            icount_q <= '0;
            stat_q   <= StatAok;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            icount_q <= icount_d;
            stat_q   <= stat_d;
        end
    end

    logic present;
    assign present = reset_n && (state_q == StRun) && !stall;

    always_comb begin
        icode       = IcNop;
        ifun        = 4'h0;
        rA          = RegNone;
        rB          = RegNone;
        valC        = '0;
        valP        = pc_q;
        instr_valid = 1'b0;
        stat        = (state_q == StHalt || state_q == StErr) ? stat_q : StatAok;
        if (present) begin
            icode       = f_icode;
            ifun        = f_ifun;
            rA          = f_ra;
            rB          = f_rb;
            valC        = f_valc;
            valP        = f_valp;
            instr_valid = 1'b1;
            stat        = f_stat;
        end
    end

    assign pc     = pc_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_y86_fetch_pc.sv
// Directed bench for y86_fetch_pc: hand-computed expectations checked with immediate assertions.
module tb_y86_fetch_pc;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [7:0]  imem_wdata;
    logic        start;
    logic        stall;
    logic        cond;
    logic [63:0] valM;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc;
    logic [2:0]  stat;
    logic        instr_valid;
    logic [31:0] icount;

    int n_run  = 0;
    int n_fail = 0;

    y86_fetch_pc #(
        .IMEM_BYTES(1024),
        .RESET_PC  (64'd0)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .start      (start),
        .stall      (stall),
        .cond       (cond),
        .valM       (valM),
        .icode      (icode),
        .ifun       (ifun),
        .rA         (rA),
        .rB         (rB),
        .valC       (valC),
        .valP       (valP),
        .pc         (pc),
        .stat       (stat),
        .instr_valid(instr_valid),
        .icount     (icount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bytes are taken from the left of v: v[79:72] goes to addr, v[71:64] to addr+1, ...
    task automatic load(input logic [63:0] addr, input logic [79:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            imem_addr  = addr + 64'(i);
            imem_wdata = v[79-8*i -: 8];
            imem_we    = 1'b1;
            tick();
        end
        imem_we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        stall   = 1'b0;
        imem_we = 1'b0;
        cond    = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        start      = 1'b0;
        stall      = 1'b0;
        cond       = 1'b0;
        valM       = '0;

        // Reset state, sampled while reset_n is still low.
        tick();
        chk("rst_pc", pc, 64'd0);
        chk("rst_icount", {32'd0, icount}, 64'd0);
        chk("rst_icode", {60'd0, icode}, 64'h1);
        chk("rst_ra", {60'd0, rA}, 64'hF);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_stat", {61'd0, stat}, 64'd1);
        reset_n = 1'b1;

        // irmovq $5,%rdx; andq %rax,%rcx; OPq ifun 4 (illegal)
        load(64'd0, 80'h30F2_0500_0000_0000_0000, 10);
        load(64'd10, 80'h6201_6400_0000_0000_0000, 4);
        chk("idle_icode", {60'd0, icode}, 64'h1);
        go();
        chk("irm_icode", {60'd0, icode}, 64'h3);
        chk("irm_ifun", {60'd0, ifun}, 64'h0);
        chk("irm_ra", {60'd0, rA}, 64'hF);
        chk("irm_rb", {60'd0, rB}, 64'h2);
        chk("irm_valc", valC, 64'd5);
        chk("irm_valp", valP, 64'd10);
        chk("irm_stat", {61'd0, stat}, 64'd1);
        chk("irm_valid", {63'd0, instr_valid}, 64'd1);
        stall = 1'b1;
        #1;
        chk("stall_valid", {63'd0, instr_valid}, 64'd0);
        chk("stall_icode", {60'd0, icode}, 64'h1);
        chk("stall_valp", valP, 64'd0);
        tick();
        chk("stall_pc", pc, 64'd0);
        chk("stall_icount", {32'd0, icount}, 64'd0);
        stall = 1'b0;
        tick();
        chk("irm_next_pc", pc, 64'd10);
        chk("irm_icount", {32'd0, icount}, 64'd1);
        chk("opq2_icode", {60'd0, icode}, 64'h6);
        chk("opq2_ifun", {60'd0, ifun}, 64'h2);
        chk("opq2_ra", {60'd0, rA}, 64'h0);
        chk("opq2_rb", {60'd0, rB}, 64'h1);
        chk("opq2_stat", {61'd0, stat}, 64'd1);
        chk("opq2_valp", valP, 64'd12);
        tick();
        chk("opq4_pc", pc, 64'd12);
        chk("opq4_ifun", {60'd0, ifun}, 64'h4);
        chk("opq4_stat", {61'd0, stat}, 64'd4);
        tick();
        chk("err_pc", pc, 64'd12);
        chk("err_stat", {61'd0, stat}, 64'd4);
        chk("err_icount", {32'd0, icount}, 64'd2);
        chk("err_icode", {60'd0, icode}, 64'h1);
        chk("err_valid", {63'd0, instr_valid}, 64'd0);

        // Conditional jump taken, with a write attempted in RUN.
        do_reset();
        load(64'd0, 80'h7020_0000_0000_0000_0000, 9);
        go();
        chk("jxx_icode", {60'd0, icode}, 64'h7);
        chk("jxx_valc", valC, 64'h20);
        chk("jxx_valp", valP, 64'd9);
        chk("jxx_ra", {60'd0, rA}, 64'hF);
        cond       = 1'b1;
        imem_addr  = 64'd0;
        imem_wdata = 8'h00;
        imem_we    = 1'b1;
        tick();
        imem_we = 1'b0;
        chk("jxx_taken_pc", pc, 64'h20);
        chk("jxx_taken_icount", {32'd0, icount}, 64'd1);
        // Reset mid-RUN.
        reset_n = 1'b0;
        tick();
        chk("midrst_pc", pc, 64'd0);
        chk("midrst_icount", {32'd0, icount}, 64'd0);
        chk("midrst_icode", {60'd0, icode}, 64'h1);
        chk("midrst_valid", {63'd0, instr_valid}, 64'd0);
        reset_n = 1'b1;
        tick();
        go();
        chk("run_we_ignored", {60'd0, icode}, 64'h7);
        cond = 1'b0;
        tick();
        chk("jxx_nt_pc", pc, 64'd9);

        // call / stalled ret / ret / ret to out-of-range address.
        do_reset();
        load(64'd0, 80'h8040_0000_0000_0000_0000, 9);
        load(64'h40, 80'h9000_0000_0000_0000_0000, 1);
        load(64'd9, 80'h9000_0000_0000_0000_0000, 1);
        go();
        chk("call_icode", {60'd0, icode}, 64'h8);
        chk("call_valc", valC, 64'h40);
        chk("call_valp", valP, 64'd9);
        tick();
        chk("call_pc", pc, 64'h40);
        chk("call_icount", {32'd0, icount}, 64'd1);
        chk("ret_icode", {60'd0, icode}, 64'h9);
        chk("ret_valp", valP, 64'h41);
        valM  = 64'd9;
        stall = 1'b1;
        #1;
        chk("ret_stall_icode", {60'd0, icode}, 64'h1);
        chk("ret_stall_valid", {63'd0, instr_valid}, 64'd0);
        tick();
        chk("ret_stall_pc", pc, 64'h40);
        chk("ret_stall_icount", {32'd0, icount}, 64'd1);
        stall = 1'b0;
        tick();
        chk("ret_pc", pc, 64'd9);
        chk("ret_icount", {32'd0, icount}, 64'd2);
        chk("ret2_icode", {60'd0, icode}, 64'h9);
        valM = 64'd2000;
        tick();
        chk("ret_far_pc", pc, 64'd2000);
        chk("ret_far_icount", {32'd0, icount}, 64'd3);
        chk("ret_far_stat", {61'd0, stat}, 64'd3);
        chk("ret_far_valid", {63'd0, instr_valid}, 64'd1);
        tick();
        chk("far_err_pc", pc, 64'd2000);
        chk("far_err_stat", {61'd0, stat}, 64'd3);
        chk("far_err_icount", {32'd0, icount}, 64'd3);
        valM = '0;

        // nop nop nop halt
        do_reset();
        load(64'd0, 80'h1010_1000_0000_0000_0000, 4);
        go();
        tick();
        tick();
        tick();
        chk("hlt_pc", pc, 64'd3);
        chk("hlt_icount", {32'd0, icount}, 64'd3);
        chk("hlt_icode", {60'd0, icode}, 64'h0);
        chk("hlt_stat", {61'd0, stat}, 64'd2);
        tick();
        chk("halt_pc", pc, 64'd3);
        chk("halt_stat", {61'd0, stat}, 64'd2);
        chk("halt_icode", {60'd0, icode}, 64'h1);
        chk("halt_icount", {32'd0, icount}, 64'd3);
        go();
        chk("halt_start_pc", pc, 64'd3);
        chk("halt_start_stat", {61'd0, stat}, 64'd2);
        chk("halt_start_valid", {63'd0, instr_valid}, 64'd0);

        // Write and start on the same edge: first fetch sees the new byte.
        do_reset();
        imem_addr  = 64'd0;
        imem_wdata = 8'hC0;
        imem_we    = 1'b1;
        start      = 1'b1;
        tick();
        imem_we = 1'b0;
        start   = 1'b0;
        chk("ins_icode", {60'd0, icode}, 64'hC);
        chk("ins_stat", {61'd0, stat}, 64'd4);
        tick();
        chk("ins_err_pc", pc, 64'd0);
        chk("ins_err_stat", {61'd0, stat}, 64'd4);
        chk("ins_err_icount", {32'd0, icount}, 64'd0);

        // jmp 1019; irmovq with bad ifun runs off the end: ADR beats INS.
        do_reset();
        load(64'd0, 80'h70FB_0300_0000_0000_0000, 9);
        load(64'd1019, 80'h3100_0000_0000_0000_0000, 1);
        go();
        cond = 1'b1;
        tick();
        chk("adr_pc", pc, 64'd1019);
        chk("adr_icode", {60'd0, icode}, 64'h3);
        chk("adr_ifun", {60'd0, ifun}, 64'h1);
        chk("adr_stat", {61'd0, stat}, 64'd3);
        tick();
        chk("adr_err_pc", pc, 64'd1019);
        chk("adr_err_stat", {61'd0, stat}, 64'd3);
        chk("adr_err_icount", {32'd0, icount}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
